// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle: id_* fields produced by decode, ex_* fields held by the ID/EX register.
// master = decode side (drives id_*), slave = the ID/EX register (drives ex_*).
interface id_ex_stage_reg_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RWIDTH = 5
);
    logic              id_valid;
    logic              id_RegDst, id_Branch, id_MemRead, id_MemtoReg;
    logic              id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [RWIDTH-1:0] id_rs, id_rt, id_rd;
    logic [DWIDTH-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic [5:0]        id_funct;

    logic              ex_valid;
    logic              ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg;
    logic              ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [RWIDTH-1:0] ex_rs, ex_rt, ex_rd;
    logic [DWIDTH-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [5:0]        ex_funct;

    modport master (
        output id_valid, id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite,
               id_ALUSrc, id_RegWrite, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_pc4, id_funct,
        input  ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
               ex_ALUSrc, ex_RegWrite, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
               ex_pc4, ex_funct
    );

    modport slave (
        input  id_valid, id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite,
               id_ALUSrc, id_RegWrite, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_pc4, id_funct,
        output ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
               ex_ALUSrc, ex_RegWrite, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
               ex_pc4, ex_funct
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, downstream hold
// and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RWIDTH = 5,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    id_ex_stage_reg_if.slave  bus,
    input  logic              ex_flush,
    input  logic              ex_stall,
    input  logic              cnt_clr,
    output logic              hazard_stall,
    output logic [CWIDTH-1:0] bubble_cnt
);
    typedef struct packed {
        logic              valid;
        logic [6:0]        ctl;  // {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
        logic [RWIDTH-1:0] rs;
        logic [RWIDTH-1:0] rt;
        logic [RWIDTH-1:0] rd;
        logic [DWIDTH-1:0] rdata1;
        logic [DWIDTH-1:0] rdata2;
        logic [DWIDTH-1:0] imm;
        logic [5:0]        funct;
        logic [DWIDTH-1:0] pc4;
    } ex_t;

    ex_t               ex_q, ex_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [6:0]        id_ctl;
    logic              rt_used, load_use;

    assign id_ctl = {bus.id_RegDst, bus.id_Branch, bus.id_MemRead, bus.id_MemtoReg,
                     bus.id_MemWrite, bus.id_ALUSrc, bus.id_RegWrite};

    // Stores read rt as data even though ALUSrc selects the immediate.
    assign rt_used  = ~bus.id_ALUSrc | bus.id_MemWrite;
    assign load_use = ex_q.valid & ex_q.ctl[4] & (ex_q.rt != '0) & bus.id_valid &
                      ((ex_q.rt == bus.id_rs) | (rt_used & (ex_q.rt == bus.id_rt)));
    assign hazard_stall = load_use & ~ex_flush & ~ex_stall;

    always_comb begin
        ex_d = ex_q;
        if (ex_flush || (!ex_stall && hazard_stall)) begin
            ex_d = '0;
        end else if (!ex_stall) begin
            ex_d.valid  = bus.id_valid;
            ex_d.ctl    = bus.id_valid ? id_ctl : 7'b0;
            ex_d.rs     = bus.id_rs;
            ex_d.rt     = bus.id_rt;
            ex_d.rd     = bus.id_rd;
            ex_d.rdata1 = bus.id_rdata1;
            ex_d.rdata2 = bus.id_rdata2;
            ex_d.imm    = bus.id_imm;
            ex_d.funct  = bus.id_funct;
            ex_d.pc4    = bus.id_pc4;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hazard_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CWIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_RegDst   = ex_q.ctl[6];
    assign bus.ex_Branch   = ex_q.ctl[5];
    assign bus.ex_MemRead  = ex_q.ctl[4];
    assign bus.ex_MemtoReg = ex_q.ctl[3];
    assign bus.ex_MemWrite = ex_q.ctl[2];
    assign bus.ex_ALUSrc   = ex_q.ctl[1];
    assign bus.ex_RegWrite = ex_q.ctl[0];
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_rdata1   = ex_q.rdata1;
    assign bus.ex_rdata2   = ex_q.rdata2;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_funct    = ex_q.funct;
    assign bus.ex_pc4      = ex_q.pc4;
    assign bubble_cnt      = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg against a cycle-level model of the
// pipeline register contents and the bubble counter (counter built 4 bits wide).
module tb_id_ex_stage_reg;
    localparam int SW = 161;

    logic        clk, rst, flush, stall, clr, hz;
    logic [3:0]  bcnt;
    logic        id_valid;
    logic [6:0]  id_ctl;  // {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic [5:0]  id_funct;

    int errors = 0;
    int checks = 0;

    id_ex_stage_reg_if #(.DWIDTH(32), .RWIDTH(5)) ifc ();

    assign ifc.id_valid    = id_valid;
    assign ifc.id_RegDst   = id_ctl[6];
    assign ifc.id_Branch   = id_ctl[5];
    assign ifc.id_MemRead  = id_ctl[4];
    assign ifc.id_MemtoReg = id_ctl[3];
    assign ifc.id_MemWrite = id_ctl[2];
    assign ifc.id_ALUSrc   = id_ctl[1];
    assign ifc.id_RegWrite = id_ctl[0];
    assign ifc.id_rs       = id_rs;
    assign ifc.id_rt       = id_rt;
    assign ifc.id_rd       = id_rd;
    assign ifc.id_rdata1   = id_rdata1;
    assign ifc.id_rdata2   = id_rdata2;
    assign ifc.id_imm      = id_imm;
    assign ifc.id_pc4      = id_pc4;
    assign ifc.id_funct    = id_funct;

    id_ex_stage_reg #(.DWIDTH(32), .RWIDTH(5), .CWIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (ifc),
        .ex_flush     (flush),
        .ex_stall     (stall),
        .cnt_clr      (clr),
        .hazard_stall (hz),
        .bubble_cnt   (bcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what instruction (if any) sits in EX, and how many bubbles so far.
    typedef struct packed {
        logic        valid;
        logic [6:0]  ctl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rdata1, rdata2, imm;
        logic [5:0]  funct;
        logic [31:0] pc4;
    } st_t;

    st_t m_ex;
    int  m_cnt;
    bit  hz_got, hz_exp;

    function automatic logic [SW-1:0] got_state();
        return {ifc.ex_valid, ifc.ex_RegDst, ifc.ex_Branch, ifc.ex_MemRead, ifc.ex_MemtoReg,
                ifc.ex_MemWrite, ifc.ex_ALUSrc, ifc.ex_RegWrite, ifc.ex_rs, ifc.ex_rt,
                ifc.ex_rd, ifc.ex_rdata1, ifc.ex_rdata2, ifc.ex_imm, ifc.ex_funct, ifc.ex_pc4,
                bcnt};
    endfunction

    function automatic logic [SW-1:0] exp_state();
        return {m_ex, 4'(m_cnt)};
    endfunction

    // A load in EX writing a nonzero register that the ID instruction reads.
    function automatic bit model_hazard();
        bit ex_is_load, id_reads_rt, depends;
        ex_is_load  = m_ex.valid && m_ex.ctl[4] && (m_ex.rt != 5'd0);
        id_reads_rt = !id_ctl[1] || id_ctl[2];
        depends     = (m_ex.rt == id_rs) || (id_reads_rt && (m_ex.rt == id_rt));
        return ex_is_load && id_valid && depends && !flush && !stall;
    endfunction

    task automatic model_edge(input bit bubble);
        if (clr) m_cnt = 0;
        else if (bubble && m_cnt < 15) m_cnt++;
        if (flush || bubble) begin
            m_ex = '0;
        end else if (!stall) begin
            m_ex.valid  = id_valid;
            m_ex.ctl    = id_valid ? id_ctl : 7'b0;
            m_ex.rs     = id_rs;
            m_ex.rt     = id_rt;
            m_ex.rd     = id_rd;
            m_ex.rdata1 = id_rdata1;
            m_ex.rdata2 = id_rdata2;
            m_ex.imm    = id_imm;
            m_ex.funct  = id_funct;
            m_ex.pc4    = id_pc4;
        end
    endtask

    // Sample hazard_stall mid-cycle, then take one edge; leaves time at posedge+1.
    task automatic cycle();
        @(negedge clk);
        hz_got = hz;
        hz_exp = model_hazard();
        @(posedge clk);
        model_edge(hz_exp);
        #1;
    endtask

    task automatic rand_fields();
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
        id_funct = 6'($urandom); id_ctl = 7'($urandom); id_valid = 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] ctl, input logic [4:0] rs, input logic [4:0] rt);
        rand_fields();
        id_ctl = ctl; id_rs = rs; id_rt = rt;
    endtask

    localparam logic [6:0] CtlLoad  = 7'b0011011;
    localparam logic [6:0] CtlRtype = 7'b1000001;
    localparam logic [6:0] CtlAddi  = 7'b0000011;
    localparam logic [6:0] CtlStore = 7'b0000110;

    task automatic test_reset();
        rst = 1'b0; flush = 0; stall = 0; clr = 0;
        rand_fields();
        m_ex = '0; m_cnt = 0;
        #3;
        checks++;
        if (got_state() !== exp_state()) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", got_state(), exp_state());
        end
        checks++;
        if (hz !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", hz); end
        @(posedge clk); #1;
        rst = 1'b1;
        rand_fields();
        id_rdata1 = 32'h1234_5678;
        cycle();
        checks++;
        if (ifc.ex_rdata1 !== 32'h1234_5678 || ifc.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_capture got=%h/%b exp=12345678/1", ifc.ex_rdata1, ifc.ex_valid);
        end
        checks++;
        if (got_state() !== exp_state()) begin
            errors++; $display("FAIL first_state got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_load_use_rs();
        set_instr(CtlLoad, 5'd1, 5'd5);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        set_instr(CtlRtype, 5'd5, 5'd2);
        cycle();
        checks++;
        if (hz_got !== 1'b1) begin errors++; $display("FAIL lu_rs_hazard got=%b exp=1", hz_got); end
        checks++;
        if (got_state() !== {1'b0, 156'd0, 4'd1}) begin
            errors++; $display("FAIL lu_rs_bubble got=%h exp=bubble,cnt=1", got_state());
        end
        cycle();
        checks++;
        if (hz_got !== 1'b0 || ifc.ex_valid !== 1'b1 || ifc.ex_rs !== 5'd5) begin
            errors++;
            $display("FAIL lu_rs_replay got=hz%b v%b rs%0d exp=hz0 v1 rs5",
                     hz_got, ifc.ex_valid, ifc.ex_rs);
        end
        checks++;
        if (got_state() !== exp_state()) begin
            errors++; $display("FAIL lu_rs_state got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_no_false_hazard();
        set_instr(CtlLoad, 5'd1, 5'd0);
        cycle();
        set_instr(CtlRtype, 5'd0, 5'd0);
        cycle();
        checks++;
        if (hz_got !== 1'b0) begin errors++; $display("FAIL r0_hazard got=%b exp=0", hz_got); end
        set_instr(CtlLoad, 5'd1, 5'd7);
        cycle();
        set_instr(CtlAddi, 5'd3, 5'd7);
        cycle();
        checks++;
        if (hz_got !== 1'b0) begin errors++; $display("FAIL addi_rt got=%b exp=0", hz_got); end
        set_instr(CtlLoad, 5'd1, 5'd7);
        cycle();
        set_instr(CtlStore, 5'd3, 5'd7);
        cycle();
        checks++;
        if (hz_got !== 1'b1) begin errors++; $display("FAIL store_rt got=%b exp=1", hz_got); end
        checks++;
        if (got_state() !== exp_state()) begin
            errors++; $display("FAIL store_state got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_priority();
        int cnt_before;
        logic [SW-1:0] held;
        set_instr(CtlLoad, 5'd1, 5'd9);
        cycle();
        cnt_before = m_cnt;
        set_instr(CtlRtype, 5'd9, 5'd2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (hz_got !== 1'b0 || ifc.ex_valid !== 1'b0 || int'(bcnt) != cnt_before) begin
            errors++;
            $display("FAIL flush_prio got=hz%b v%b cnt%0d exp=hz0 v0 cnt%0d",
                     hz_got, ifc.ex_valid, bcnt, cnt_before);
        end
        set_instr(CtlLoad, 5'd1, 5'd9);
        cycle();
        held = exp_state();
        set_instr(CtlRtype, 5'd9, 5'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            id_rdata1 = $urandom;
            checks++;
            if (hz_got !== 1'b0 || got_state() !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=hz%b %h exp=hz0 %h", i, hz_got, got_state(),
                         held);
            end
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (hz_got !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", hz_got); end
    endtask

    task automatic test_counter();
        set_instr(CtlRtype, 5'd1, 5'd2);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_instr(CtlLoad, 5'd1, 5'd4);
            cycle();
            set_instr(CtlRtype, 5'd4, 5'd2);
            cycle();
            checks++;
            if (int'(bcnt) != ((i + 1 > 15) ? 15 : i + 1)) begin
                errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, bcnt,
                                   (i + 1 > 15) ? 15 : i + 1);
            end
        end
        set_instr(CtlLoad, 5'd1, 5'd4);
        cycle();
        set_instr(CtlRtype, 5'd4, 5'd2);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checks++;
        if (hz_got !== 1'b1 || bcnt !== 4'd0) begin
            errors++; $display("FAIL clr_prio got=hz%b cnt%0d exp=hz1 cnt0", hz_got, bcnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            id_valid = ($urandom_range(3) != 0);
            id_rs = 5'($urandom_range(3)); id_rt = 5'($urandom_range(3));
            if ($urandom_range(1) == 1) id_ctl[4] = 1'b1;
            flush = ($urandom_range(9) == 0);
            stall = ($urandom_range(7) == 0);
            clr   = ($urandom_range(29) == 0);
            cycle();
            checks++;
            if (hz_got !== hz_exp || got_state() !== exp_state()) begin
                errors++;
                $display("FAIL random[%0d] got=hz%b %h exp=hz%b %h", i, hz_got, got_state(),
                         hz_exp, exp_state());
            end
        end
        flush = 0; stall = 0; clr = 0;
    endtask

    task automatic test_reset_mid_bubble();
        set_instr(CtlLoad, 5'd1, 5'd6);
        cycle();
        set_instr(CtlRtype, 5'd6, 5'd2);
        #2;
        checks++;
        if (hz !== 1'b1) begin errors++; $display("FAIL pre_reset_hazard got=%b exp=1", hz); end
        rst = 1'b0;
        m_ex = '0; m_cnt = 0;
        #1;
        checks++;
        if (hz !== 1'b0 || got_state() !== exp_state()) begin
            errors++; $display("FAIL mid_reset got=hz%b %h exp=hz0 zeros", hz, got_state());
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use_rs();
        test_no_false_hazard();
        test_priority();
        test_counter();
        test_random();
        test_reset_mid_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
